// File: rtl/jt89_wr_sched.sv
// jt89_wr_sched: arbitrates two register-level requesters plus a "mute all"
// request onto the jt89 PSG byte write bus (wr_n/din). It paces each byte as
// WR_LOW cycles low and WR_HIGH cycles high. Tone writes go out as two bytes
// that are never split by another command.
module jt89_wr_sched #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [2:0] a_reg,
  input  logic [9:0] a_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [2:0] b_reg,
  input  logic [9:0] b_data,
  input  logic       mute,
  output logic       mute_done,
  output logic       busy,
  output logic       wr_n,
  output logic [7:0] din
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  localparam logic [3:0] LOW_LD  = 4'(WR_LOW - 1);
  localparam logic [3:0] HIGH_LD = 4'(WR_HIGH - 1);
  localparam bit         HIGH1   = (WR_HIGH == 1);

  state_t          r_state;
  logic [3:0]      r_phase;
  logic [3:0][7:0] r_bytes;
  logic [1:0]      r_idx;
  logic [1:0]      r_last;
  logic            r_is_mute;
  logic            r_rr;        // 0: A wins a tie, 1: B wins a tie
  logic            r_mute_pend;
  logic            r_wr_n;
  logic [7:0]      r_din;
  logic            r_mute_done;

  logic       w_idle, w_a_ready, w_b_ready, w_tone, w_last, w_mdone_nxt, w_mute_act;
  logic [2:0] w_reg;
  logic [9:0] w_data;
  logic [7:0] w_b0, w_b1;

  // Arbitration and byte encoding for the command that would be accepted now
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_a_ready   = w_idle & ~r_mute_pend & a_valid & (~b_valid | ~r_rr);
    w_b_ready   = w_idle & ~r_mute_pend & b_valid & (~a_valid |  r_rr);
    w_reg       = w_a_ready ? a_reg  : b_reg;
    w_data      = w_a_ready ? a_data : b_data;
    w_tone      = ~w_reg[0] & (w_reg != 3'd6);
    w_b0        = {1'b1, w_reg, w_data[3:0]};
    w_b1        = {2'b00, w_data[9:4]};
    w_last      = (r_idx == r_last);
    w_mute_act  = r_is_mute & ~w_idle;
    // mute_done is registered, so raise it one cycle ahead of the final HIGH cycle
    w_mdone_nxt = r_is_mute & w_last &
                  (((r_state == S_LOW) & (r_phase == 4'd0) & HIGH1) |
                   ((r_state == S_HIGH) & (r_phase == 4'd1)));
  end

  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;
  assign busy      = ~w_idle | r_mute_pend;
  assign wr_n      = r_wr_n;
  assign din       = r_din;
  assign mute_done = r_mute_done;

  // Write sequencer: IDLE picks the next job, then LOW/HIGH pace each byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= 4'd0;
      r_bytes     <= '0;
      r_idx       <= 2'd0;
      r_last      <= 2'd0;
      r_is_mute   <= 1'b0;
      r_rr        <= 1'b0;
      r_mute_pend <= 1'b0;
      r_wr_n      <= 1'b1;
      r_din       <= 8'h00;
      r_mute_done <= 1'b0;
    end else begin
      r_mute_done <= w_mdone_nxt;
      // A mute that arrives while one is running is absorbed
      if (mute && !w_mute_act) r_mute_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_mute_pend) begin
            r_mute_pend <= 1'b0;
            r_bytes     <= {8'hFF, 8'hDF, 8'hBF, 8'h9F};
            r_last      <= 2'd3;
            r_idx       <= 2'd0;
            r_is_mute   <= 1'b1;
            r_din       <= 8'h9F;
            r_wr_n      <= 1'b0;
            r_phase     <= LOW_LD;
            r_state     <= S_LOW;
          end else if (w_a_ready || w_b_ready) begin
            r_bytes   <= {8'h00, 8'h00, w_b1, w_b0};
            r_last    <= w_tone ? 2'd1 : 2'd0;
            r_idx     <= 2'd0;
            r_is_mute <= 1'b0;
            r_din     <= w_b0;
            r_wr_n    <= 1'b0;
            r_phase   <= LOW_LD;
            r_state   <= S_LOW;
            r_rr      <= w_a_ready;
          end
        end
        S_LOW: begin
          if (r_phase == 4'd0) begin
            r_wr_n  <= 1'b1;
            r_phase <= HIGH_LD;
            r_state <= S_HIGH;
          end else begin
            r_phase <= r_phase - 4'd1;
          end
        end
        S_HIGH: begin
          if (r_phase != 4'd0) begin
            r_phase <= r_phase - 4'd1;
          end else if (w_last) begin
            r_state   <= S_IDLE;
            r_is_mute <= 1'b0;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_din   <= r_bytes[r_idx + 2'd1];
            r_wr_n  <= 1'b0;
            r_phase <= LOW_LD;
            r_state <= S_LOW;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
